// File: rtl/vxe_cu_dispatch_ctrl_if.sv
// Command-queue and VPU-side signal bundle of the CU dispatcher.
// master = dispatcher view, slave = queue/VPU side view.
interface vxe_cu_dispatch_ctrl_if #(
  parameter int NR_VPUS = 2,
  parameter int CMDW    = 56
);
  logic               i_cmd_valid;
  logic [CMDW-1:0]    i_cmd_data;
  logic [NR_VPUS-1:0] i_cmd_dst;
  logic               o_cmd_rd;
  logic [NR_VPUS-1:0] o_vpu_valid;
  logic [CMDW-1:0]    o_vpu_data;
  logic [NR_VPUS-1:0] i_vpu_rdy;

  modport master (
    input  i_cmd_valid, i_cmd_data, i_cmd_dst, i_vpu_rdy,
    output o_cmd_rd, o_vpu_valid, o_vpu_data
  );

  modport slave (
    output i_cmd_valid, i_cmd_data, i_cmd_dst, i_vpu_rdy,
    input  o_cmd_rd, o_vpu_valid, o_vpu_data
  );
endinterface

// File: rtl/vxe_cu_dispatch_ctrl.sv
// Pops decoded commands and multicasts them to VPUs, 1-cycle pop-to-valid latency;
// the next pop waits until every targeted VPU has accepted, halt drains then parks.
module vxe_cu_dispatch_ctrl #(
  parameter int NR_VPUS = 2,
  parameter int CMDW    = 56
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_halt,
  input  logic                          i_unhalt,
  vxe_cu_dispatch_ctrl_if.master        bus,
  output logic                          o_active,
  output logic                          o_halted,
  output logic                          o_err_dst
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NR_VPUS-1:0] pend_q, pend_d;
  logic [CMDW-1:0]    data_q, data_d;
  logic               active_q, active_d;
  logic               halted_q, halted_d;
  logic               err_q, err_d;

  logic [NR_VPUS-1:0] pend_nx;
  logic               halt_req;
  logic               load;

  always_comb begin
    pend_nx  = pend_q & ~bus.i_vpu_rdy;
    halt_req = (state_q == ST_RUN) & i_halt;
    // rst gates the pop so the queue head is never consumed while in reset
    load     = ~rst & (state_q == ST_RUN) & ~halt_req & bus.i_cmd_valid &
               (pend_nx == '0);

    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (i_halt) state_d = (pend_nx == '0) ? ST_HALTED : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (i_unhalt)              state_d = ST_RUN;
        else if (pend_nx == '0)    state_d = ST_HALTED;
      end
      ST_HALTED: begin
        if (i_unhalt) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    pend_d   = load ? bus.i_cmd_dst  : pend_nx;
    data_d   = load ? bus.i_cmd_data : data_q;
    active_d = (pend_d != '0);
    halted_d = (state_d == ST_HALTED);
    err_d    = load & (bus.i_cmd_dst == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      pend_q   <= '0;
      data_q   <= '0;
      active_q <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      data_q   <= data_d;
      active_q <= active_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign bus.o_cmd_rd    = load;
  assign bus.o_vpu_valid = pend_q;
  assign bus.o_vpu_data  = data_q;
  assign o_active        = active_q;
  assign o_halted        = halted_q;
  assign o_err_dst       = err_q;

endmodule

// File: tb/tb_vxe_cu_dispatch_ctrl.sv
// Per-cycle vector table for control outputs plus a pop-order scoreboard for data.
module tb_vxe_cu_dispatch_ctrl;

  localparam int NV = 2;
  localparam int CW = 56;

  localparam logic [CW-1:0] DA = 56'hA5_0000_0001;
  localparam logic [CW-1:0] DB = 56'h11_2233_4455_6677;
  localparam logic [CW-1:0] DC = 56'h00_C0FF_EE00_0001;
  localparam logic [CW-1:0] E0 = 56'hE0_0000_0000_0010;
  localparam logic [CW-1:0] E1 = 56'hE1_0000_0000_0011;
  localparam logic [CW-1:0] E2 = 56'hE2_0000_0000_0012;
  localparam logic [CW-1:0] E3 = 56'hE3_0000_0000_0013;
  localparam logic [CW-1:0] F0 = 56'hF0_F0F0_F0F0_F0F0;
  localparam logic [CW-1:0] F1 = 56'hF1_0F0F_0F0F_0F0F;
  localparam logic [CW-1:0] G0 = 56'h60_6060_6060_6060;
  localparam logic [CW-1:0] H0 = 56'h40_0000_0000_ABCD;
  localparam logic [CW-1:0] H1 = 56'h41_0000_0000_DCBA;
  localparam logic [CW-1:0] Z0 = 56'h2E_0000_0000_0BAD;
  localparam logic [CW-1:0] K0 = 56'h7F_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst, i_halt, i_unhalt;
  logic o_active, o_halted, o_err_dst;

  vxe_cu_dispatch_ctrl_if #(.NR_VPUS(NV), .CMDW(CW)) bus ();

  vxe_cu_dispatch_ctrl #(.NR_VPUS(NV), .CMDW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_halt    (i_halt),
    .i_unhalt  (i_unhalt),
    .bus       (bus),
    .o_active  (o_active),
    .o_halted  (o_halted),
    .o_err_dst (o_err_dst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst, halt, unhalt, cv;
    logic [CW-1:0] data;
    logic [NV-1:0] dst, rdy;
    logic          e_rd;
    logic [NV-1:0] e_vv;
    logic          e_act, e_hlt, e_err;
  } vec_t;

  typedef struct {
    logic [CW-1:0] data;
    logic [NV-1:0] dst;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   tests = 0;
  int   fails = 0;

  function automatic vec_t mk(logic r, logic h, logic u, logic cv, logic [CW-1:0] d,
                              logic [NV-1:0] dst, logic [NV-1:0] rdy, logic e_rd,
                              logic [NV-1:0] e_vv, logic e_act, logic e_hlt, logic e_err);
    vec_t v;
    v.rst = r; v.halt = h; v.unhalt = u; v.cv = cv; v.data = d; v.dst = dst; v.rdy = rdy;
    v.e_rd = e_rd; v.e_vv = e_vv; v.e_act = e_act; v.e_hlt = e_hlt; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    rst             = v.rst;
    i_halt          = v.halt;
    i_unhalt        = v.unhalt;
    bus.i_cmd_valid = v.cv;
    bus.i_cmd_data  = v.data;
    bus.i_cmd_dst   = v.dst;
    bus.i_vpu_rdy   = v.rdy;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic  popped;
    logic  got;
    sb_t   s;
    vec_t  idle;

    rst = 1'b1; i_halt = 1'b0; i_unhalt = 1'b0;
    bus.i_cmd_valid = 1'b0; bus.i_cmd_data = '0; bus.i_cmd_dst = '0; bus.i_vpu_rdy = '0;

    idle = mk(0,0,0,0,'0,2'b00,2'b11, 0,2'b00,0,0,0);
    // reset held with a valid queue head
    repeat (3) vecs.push_back(mk(1,0,0,1,DB,2'b11,2'b11, 0,2'b00,0,0,0));
    vecs.push_back(idle);
    // unicast
    vecs.push_back(mk(0,0,0,1,DA,2'b01,2'b11, 1,2'b00,0,0,0));
    vecs.push_back(mk(0,0,0,0,'0,2'b00,2'b11, 0,2'b01,1,0,0));
    vecs.push_back(idle);
    // multicast with staggered ready, second command waiting
    vecs.push_back(mk(0,0,0,1,DB,2'b11,2'b01, 1,2'b00,0,0,0));
    vecs.push_back(mk(0,0,0,1,DC,2'b01,2'b01, 0,2'b11,1,0,0));
    vecs.push_back(mk(0,0,0,1,DC,2'b01,2'b01, 0,2'b10,1,0,0));
    vecs.push_back(mk(0,0,0,1,DC,2'b01,2'b01, 0,2'b10,1,0,0));
    vecs.push_back(mk(0,0,0,1,DC,2'b01,2'b11, 1,2'b10,1,0,0));
    vecs.push_back(mk(0,0,0,0,'0,2'b00,2'b11, 0,2'b01,1,0,0));
    vecs.push_back(idle);
    // streaming, one pop per cycle
    vecs.push_back(mk(0,0,0,1,E0,2'b10,2'b11, 1,2'b00,0,0,0));
    vecs.push_back(mk(0,0,0,1,E1,2'b10,2'b11, 1,2'b10,1,0,0));
    vecs.push_back(mk(0,0,0,1,E2,2'b10,2'b11, 1,2'b10,1,0,0));
    vecs.push_back(mk(0,0,0,1,E3,2'b10,2'b11, 1,2'b10,1,0,0));
    vecs.push_back(mk(0,0,0,0,'0,2'b00,2'b11, 0,2'b10,1,0,0));
    vecs.push_back(idle);
    // halt mid-flight, drain, park, unhalt
    vecs.push_back(mk(0,0,0,1,F0,2'b11,2'b00, 1,2'b00,0,0,0));
    vecs.push_back(mk(0,1,0,1,F1,2'b01,2'b00, 0,2'b11,1,0,0));
    vecs.push_back(mk(0,0,0,1,F1,2'b01,2'b00, 0,2'b11,1,0,0));
    vecs.push_back(mk(0,0,0,1,F1,2'b01,2'b11, 0,2'b11,1,0,0));
    vecs.push_back(mk(0,0,0,1,F1,2'b01,2'b11, 0,2'b00,0,1,0));
    vecs.push_back(mk(0,0,1,1,F1,2'b01,2'b11, 0,2'b00,0,1,0));
    vecs.push_back(mk(0,0,0,1,F1,2'b01,2'b11, 1,2'b00,0,0,0));
    vecs.push_back(mk(0,0,0,0,'0,2'b00,2'b11, 0,2'b01,1,0,0));
    vecs.push_back(idle);
    // halt+unhalt together: halt wins in RUN, unhalt wins in HALTED
    vecs.push_back(mk(0,1,1,1,G0,2'b01,2'b11, 0,2'b00,0,0,0));
    vecs.push_back(mk(0,0,0,1,G0,2'b01,2'b11, 0,2'b00,0,1,0));
    vecs.push_back(mk(0,1,1,1,G0,2'b01,2'b11, 0,2'b00,0,1,0));
    vecs.push_back(mk(0,0,0,1,G0,2'b01,2'b11, 1,2'b00,0,0,0));
    vecs.push_back(mk(0,0,0,0,'0,2'b00,2'b11, 0,2'b01,1,0,0));
    vecs.push_back(idle);
    // unhalt during drain cancels it, pend untouched
    vecs.push_back(mk(0,0,0,1,H0,2'b10,2'b00, 1,2'b00,0,0,0));
    vecs.push_back(mk(0,1,0,0,'0,2'b00,2'b00, 0,2'b10,1,0,0));
    vecs.push_back(mk(0,0,1,1,H1,2'b01,2'b00, 0,2'b10,1,0,0));
    vecs.push_back(mk(0,0,0,1,H1,2'b01,2'b10, 1,2'b10,1,0,0));
    vecs.push_back(mk(0,0,0,0,'0,2'b00,2'b11, 0,2'b01,1,0,0));
    vecs.push_back(idle);
    // zero destination mask
    vecs.push_back(mk(0,0,0,1,Z0,2'b00,2'b11, 1,2'b00,0,0,0));
    vecs.push_back(mk(0,0,0,0,'0,2'b00,2'b11, 0,2'b00,0,0,1));
    vecs.push_back(idle);

    popped = 1'b0;
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i]);
      @(negedge clk);
      chk($sformatf("v%0d_cmd_rd", i), 64'(bus.o_cmd_rd),    64'(vecs[i].e_rd));
      chk($sformatf("v%0d_vpu_vld", i), 64'(bus.o_vpu_valid), 64'(vecs[i].e_vv));
      chk($sformatf("v%0d_active", i), 64'(o_active),        64'(vecs[i].e_act));
      chk($sformatf("v%0d_halted", i), 64'(o_halted),        64'(vecs[i].e_hlt));
      chk($sformatf("v%0d_err_dst", i), 64'(o_err_dst),      64'(vecs[i].e_err));
      if (popped) begin
        if (sbq.size() == 0) begin
          chk($sformatf("v%0d_sb_underflow", i), 64'(1), 64'(0));
        end else begin
          s = sbq.pop_front();
          chk($sformatf("v%0d_sb_data", i), 64'(bus.o_vpu_data), 64'(s.data));
          if (s.dst == '0) chk($sformatf("v%0d_sb_err", i), 64'(o_err_dst), 64'(1));
          else             chk($sformatf("v%0d_sb_mask", i), 64'(bus.o_vpu_valid), 64'(s.dst));
        end
      end
      popped = vecs[i].e_rd & ~vecs[i].rst;
      if (popped) begin
        s.data = vecs[i].data;
        s.dst  = vecs[i].dst;
        sbq.push_back(s);
      end
    end

    // reset while a multicast is stalled
    @(posedge clk); #1;
    drive(mk(0,0,0,1,K0,2'b11,2'b00, 0,2'b00,0,0,0));
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      @(negedge clk);
      if (bus.o_cmd_rd) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("rst_mid_pop_seen", 64'(got), 64'(1));
    @(posedge clk); #1;
    bus.i_cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_vld_before", 64'(bus.o_vpu_valid), 64'(2'b11));
    chk("rst_mid_data_before", 64'(bus.o_vpu_data), 64'(K0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_cmd_rd_in_rst", 64'(bus.o_cmd_rd), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_vld_after", 64'(bus.o_vpu_valid), 64'(0));
    chk("rst_mid_active_after", 64'(o_active), 64'(0));
    chk("rst_mid_data_after", 64'(bus.o_vpu_data), 64'(0));
    @(posedge clk); #1;
    bus.i_vpu_rdy = 2'b11;
    @(negedge clk);
    chk("rst_mid_no_reassert", 64'(bus.o_vpu_valid), 64'(0));

    chk("sb_queue_empty", 64'(sbq.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
